mem_access_unit: RTL and testbench

//  Parametrised MEM-stage load/store engine. Drives a variable-latency RAM bus (req/ack) with byte/half/word

---
 rtl/mem_access_unit_pkg.sv | 17 +
 rtl/mem_access_unit_load_align.sv | 26 ++
 rtl/mem_access_unit.sv | 186 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage load/store engine: access-size codes and FSM states.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MemSizeB = 2'b00,
    MemSizeH = 2'b01,
    MemSizeW = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone,
    StDrain
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load alignment: shifts the addressed field down to bit 0 and zero/sign-extends it.
module mem_load_align
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]           rdata,
  input  logic [$clog2(DATA_W/8)-1:0] lane,
  input  logic [1:0]                  size,
  input  logic                        sign_ext,
  output logic [DATA_W-1:0]           data
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    case (size)
      MemSizeB: data = sign_ext ? DATA_W'($signed(shifted[7:0]))  : DATA_W'(shifted[7:0]);
      MemSizeH: data = sign_ext ? DATA_W'($signed(shifted[15:0])) : DATA_W'(shifted[15:0]);
      MemSizeW: data = sign_ext ? DATA_W'($signed(shifted[31:0])) : DATA_W'(shifted[31:0]);
      default:  data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: drives a req/ack RAM bus with lane steering, aligns load data,
// flags misaligned accesses and bus timeouts, and stalls the pipeline while a request is pending.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_in,
  input  logic                  wr_in,
  input  logic                  sign_ext_in,
  input  logic [1:0]            size_in,
  input  logic [ADDR_W-1:0]     addr_in,
  input  logic [DATA_W-1:0]     wdata_in,
  input  logic                  flush,
  output logic                  ram_req,
  output logic [DATA_W/8-1:0]   ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic                  ram_ack,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic                  stall_req,
  output logic                  load_valid,
  output logic [DATA_W-1:0]     load_data,
  output logic                  exc_adel,
  output logic                  exc_ades,
  output logic                  exc_buserr,
  output logic [ADDR_W-1:0]     bad_addr
);

  localparam int unsigned LN = DATA_W / 8;
  localparam int unsigned LB = $clog2(LN);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  mau_state_e        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              req_q, req_d;
  logic [LN-1:0]     we_q, we_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic              is_load_q, is_load_d;
  logic              buserr_q, buserr_d;
  logic [DATA_W-1:0] ldata_q, ldata_d;

  logic              misaligned, legal_size, op_req, timeout_hit;
  logic [LB-1:0]     lane;
  logic [LN-1:0]     we_base;
  logic [DATA_W-1:0] aligned;

  assign lane        = addr_in[LB-1:0];
  assign misaligned  = (size_in == MemSizeH && addr_in[0]) ||
                       (size_in == MemSizeW && addr_in[1:0] != 2'b00);
  assign legal_size  = (size_in == MemSizeB) || (size_in == MemSizeH) || (size_in == MemSizeW);
  assign op_req      = (rd_in || wr_in) && legal_size && !misaligned;
  assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    case (size_in)
      MemSizeB: we_base = LN'(4'b0001);
      MemSizeH: we_base = LN'(4'b0011);
      MemSizeW: we_base = LN'(4'b1111);
      default:  we_base = '0;
    endcase
  end

  // Align using the latched op so a flushed/changed EX input cannot corrupt the capture.
  mem_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .rdata    (ram_rdata),
    .lane     (addr_q[LB-1:0]),
    .size     (size_q),
    .sign_ext (sign_q),
    .data     (aligned)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    req_d     = req_q;
    we_d      = we_q;
    raddr_d   = raddr_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    size_d    = size_q;
    sign_d    = sign_q;
    is_load_d = is_load_q;
    buserr_d  = buserr_q;
    ldata_d   = ldata_q;
    stall_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (op_req && !flush) begin
          stall_req = 1'b1;
          req_d     = 1'b1;
          we_d      = wr_in ? (we_base << lane) : '0;
          raddr_d   = {addr_in[ADDR_W-1:LB], {LB{1'b0}}};
          wdata_d   = wdata_in << {lane, 3'b000};
          addr_d    = addr_in;
          size_d    = size_in;
          sign_d    = sign_ext_in;
          is_load_d = rd_in;
          buserr_d  = 1'b0;
          timer_d   = '0;
          state_d   = StWait;
        end
      end
      StWait: begin
        stall_req = 1'b1;
        timer_d   = timer_q + TW'(1);
        if (ram_ack) begin
          req_d   = 1'b0;
          ldata_d = flush ? ldata_q : aligned;
          state_d = flush ? StIdle : StDone;
        end else if (timeout_hit) begin
          req_d    = 1'b0;
          buserr_d = !flush;
          state_d  = flush ? StIdle : StDone;
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StDrain: begin
        // The flushed transaction still owns the bus; a new op must wait for it.
        stall_req = op_req && !flush;
        timer_d   = timer_q + TW'(1);
        if (ram_ack || timeout_hit) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      req_q     <= 1'b0;
      we_q      <= '0;
      raddr_q   <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      size_q    <= 2'b00;
      sign_q    <= 1'b0;
      is_load_q <= 1'b0;
      buserr_q  <= 1'b0;
      ldata_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      req_q     <= req_d;
      we_q      <= we_d;
      raddr_q   <= raddr_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      sign_q    <= sign_d;
      is_load_q <= is_load_d;
      buserr_q  <= buserr_d;
      ldata_q   <= ldata_d;
    end
  end

  assign ram_req    = req_q;
  assign ram_we     = we_q;
  assign ram_addr   = raddr_q;
  assign ram_wdata  = wdata_q;
  assign load_data  = ldata_q;
  assign load_valid = (state_q == StDone) && is_load_q && !buserr_q;
  assign exc_buserr = (state_q == StDone) && buserr_q;
  assign exc_adel   = rd_in && misaligned;
  assign exc_ades   = wr_in && misaligned;
  assign bad_addr   = exc_buserr ? addr_q : addr_in;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (32-bit bus, TIMEOUT=4).
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_in = 1'b0, wr_in = 1'b0, sign_ext_in = 1'b0, flush = 1'b0;
  logic [1:0]  size_in = 2'b00;
  logic [31:0] addr_in = '0, wdata_in = '0;
  logic        ram_req, ram_ack = 1'b0;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata = '0;
  logic        stall_req, load_valid, exc_adel, exc_ades, exc_buserr;
  logic [31:0] load_data, bad_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_in       (rd_in),
    .wr_in       (wr_in),
    .sign_ext_in (sign_ext_in),
    .size_in     (size_in),
    .addr_in     (addr_in),
    .wdata_in    (wdata_in),
    .flush       (flush),
    .ram_req     (ram_req),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_ack     (ram_ack),
    .ram_rdata   (ram_rdata),
    .stall_req   (stall_req),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .exc_adel    (exc_adel),
    .exc_ades    (exc_ades),
    .exc_buserr  (exc_buserr),
    .bad_addr    (bad_addr)
  );

  // Presents one op, acks at cycle ack_at (-1 = never), retires the op once stall drops.
  task automatic run_op(input logic rd, input logic wr, input logic sext, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd, input int ack_at,
                        input logic [31:0] rdata, output int n_stall, output int n_valid,
                        output int n_req, output int n_buserr, output logic [31:0] ld,
                        output logic [31:0] addr1, output logic [31:0] wdata1,
                        output logic [31:0] bad, output logic [3:0] we1);
    n_stall = 0; n_valid = 0; n_req = 0; n_buserr = 0;
    ld = '0; addr1 = '0; wdata1 = '0; bad = '0; we1 = '0;
    @(negedge clk);
    rd_in = rd; wr_in = wr; sign_ext_in = sext; size_in = sz; addr_in = addr; wdata_in = wd;
    for (int c = 0; c < 12; c++) begin
      ram_ack   = (c == ack_at);
      ram_rdata = (c == ack_at) ? rdata : 32'h0;
      #1;
      if (stall_req) n_stall++;
      if (ram_req) n_req++;
      if (load_valid) begin n_valid++; ld = load_data; end
      if (exc_buserr) begin n_buserr++; bad = bad_addr; end
      if (c == 1) begin we1 = ram_we; addr1 = ram_addr; wdata1 = ram_wdata; end
      if (!stall_req) begin rd_in = 1'b0; wr_in = 1'b0; end
      @(negedge clk);
    end
    ram_ack = 1'b0;
    rd_in = 1'b0; wr_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (ram_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", ram_req); end
    checks++; if (ram_we !== 4'h0) begin errors++; $display("FAIL reset_we: got %h want 0", ram_we); end
    checks++; if (ram_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", ram_addr); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_ldata: got %h want 0", load_data); end
    checks++; if ({load_valid, exc_buserr} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b want 00", {load_valid, exc_buserr});
    end
  endtask

  task automatic test_lw();
    int ns, nv, nr, nb; logic [31:0] ld, a1, w1, bd; logic [3:0] we1;
    run_op(1'b1, 1'b0, 1'b0, MemSizeW, 32'h100, 32'h0, 3, 32'hDEADBEEF,
           ns, nv, nr, nb, ld, a1, w1, bd, we1);
    checks++; if (ns != 4) begin errors++; $display("FAIL lw_stall: got %0d want 4", ns); end
    checks++; if (nv != 1) begin errors++; $display("FAIL lw_valid: got %0d want 1", nv); end
    checks++; if (ld !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", ld); end
    checks++; if (a1 !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h want 100", a1); end
    checks++; if (we1 !== 4'h0) begin errors++; $display("FAIL lw_we: got %h want 0", we1); end
    checks++; if (nr != 3) begin errors++; $display("FAIL lw_req_cycles: got %0d want 3", nr); end
  endtask

  task automatic test_load_extend();
    int ns, nv, nr, nb; logic [31:0] ld, a1, w1, bd; logic [3:0] we1;
    run_op(1'b1, 1'b0, 1'b1, MemSizeB, 32'h103, 32'h0, 1, 32'h80112233,
           ns, nv, nr, nb, ld, a1, w1, bd, we1);
    checks++; if (ld !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", ld); end
    checks++; if (ns != 2) begin errors++; $display("FAIL lb_stall: got %0d want 2", ns); end
    run_op(1'b1, 1'b0, 1'b0, MemSizeB, 32'h103, 32'h0, 1, 32'h80112233,
           ns, nv, nr, nb, ld, a1, w1, bd, we1);
    checks++; if (ld !== 32'h00000080) begin errors++; $display("FAIL lbu_data: got %h want 00000080", ld); end
    run_op(1'b1, 1'b0, 1'b1, MemSizeH, 32'h102, 32'h0, 2, 32'h80112233,
           ns, nv, nr, nb, ld, a1, w1, bd, we1);
    checks++; if (ld !== 32'hFFFF8011) begin errors++; $display("FAIL lh_data: got %h want ffff8011", ld); end
    run_op(1'b1, 1'b0, 1'b0, MemSizeH, 32'h100, 32'h0, 1, 32'h8011A233,
           ns, nv, nr, nb, ld, a1, w1, bd, we1);
    checks++; if (ld !== 32'h0000A233) begin errors++; $display("FAIL lhu_data: got %h want 0000a233", ld); end
  endtask

  task automatic test_store();
    int ns, nv, nr, nb; logic [31:0] ld, a1, w1, bd; logic [3:0] we1;
    run_op(1'b0, 1'b1, 1'b0, MemSizeH, 32'h102, 32'h0000ABCD, 1, 32'h0,
           ns, nv, nr, nb, ld, a1, w1, bd, we1);
    checks++; if (we1 !== 4'b1100) begin errors++; $display("FAIL sh_we: got %b want 1100", we1); end
    checks++; if (w1 !== 32'hABCD0000) begin errors++; $display("FAIL sh_wdata: got %h want abcd0000", w1); end
    checks++; if (a1 !== 32'h100) begin errors++; $display("FAIL sh_addr: got %h want 100", a1); end
    checks++; if (nv != 0) begin errors++; $display("FAIL sh_no_valid: got %0d want 0", nv); end
    run_op(1'b0, 1'b1, 1'b0, MemSizeB, 32'h201, 32'h0000005A, 1, 32'h0,
           ns, nv, nr, nb, ld, a1, w1, bd, we1);
    checks++; if (we1 !== 4'b0010) begin errors++; $display("FAIL sb_we: got %b want 0010", we1); end
    checks++; if (w1[15:8] !== 8'h5A) begin errors++; $display("FAIL sb_wdata: got %h want 5a", w1[15:8]); end
    run_op(1'b0, 1'b1, 1'b0, MemSizeW, 32'h104, 32'h01020304, 2, 32'h0,
           ns, nv, nr, nb, ld, a1, w1, bd, we1);
    checks++; if ({we1, w1} !== {4'hF, 32'h01020304}) begin
      errors++; $display("FAIL sw_we_data: got %h/%h want f/01020304", we1, w1);
    end
  endtask

  task automatic test_misaligned();
    int reqs;
    @(negedge clk);
    rd_in = 1'b1; size_in = MemSizeH; addr_in = 32'h101;
    #1;
    checks++; if ({exc_adel, exc_ades} !== 2'b10) begin
      errors++; $display("FAIL lh_misalign_exc: got %b want 10", {exc_adel, exc_ades});
    end
    checks++; if (bad_addr !== 32'h101) begin errors++; $display("FAIL lh_bad_addr: got %h want 101", bad_addr); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL lh_misalign_stall: got %b want 0", stall_req); end
    reqs = 0;
    for (int c = 0; c < 3; c++) begin @(negedge clk); #1; if (ram_req) reqs++; end
    checks++; if (reqs != 0) begin errors++; $display("FAIL lh_misalign_req: got %0d want 0", reqs); end
    rd_in = 1'b0; wr_in = 1'b1; size_in = MemSizeW; addr_in = 32'h102;
    #1;
    checks++; if ({exc_adel, exc_ades, bad_addr} !== {2'b01, 32'h102}) begin
      errors++; $display("FAIL sw_misalign: got %b/%h want 01/102", {exc_adel, exc_ades}, bad_addr);
    end
    size_in = 2'b11; addr_in = 32'h100;
    #1;
    checks++; if ({stall_req, exc_adel, exc_ades} !== 3'b000) begin
      errors++; $display("FAIL illegal_size: got %b want 000", {stall_req, exc_adel, exc_ades});
    end
    wr_in = 1'b0; size_in = MemSizeB;
  endtask

  task automatic test_timeout();
    int ns, nv, nr, nb; logic [31:0] ld, a1, w1, bd; logic [3:0] we1;
    // Ack arrives in DONE, after the timeout, and must be ignored.
    run_op(1'b1, 1'b0, 1'b0, MemSizeW, 32'h200, 32'h0, 5, 32'h5555AAAA,
           ns, nv, nr, nb, ld, a1, w1, bd, we1);
    checks++; if (nr != 4) begin errors++; $display("FAIL to_req_cycles: got %0d want 4", nr); end
    checks++; if (nb != 1) begin errors++; $display("FAIL to_buserr: got %0d want 1", nb); end
    checks++; if (bd !== 32'h200) begin errors++; $display("FAIL to_bad_addr: got %h want 200", bd); end
    checks++; if (nv != 0) begin errors++; $display("FAIL to_no_valid: got %0d want 0", nv); end
    checks++; if (ns != 5) begin errors++; $display("FAIL to_stall: got %0d want 5", ns); end
  endtask

  task automatic test_flush_drain();
    @(negedge clk);
    rd_in = 1'b1; size_in = MemSizeW; addr_in = 32'h300; sign_ext_in = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL fl_wait_stall: got %b want 1", stall_req); end
    @(negedge clk);
    flush = 1'b0; addr_in = 32'h400;
    #1;
    checks++; if ({stall_req, ram_req, ram_addr} !== {2'b11, 32'h300}) begin
      errors++; $display("FAIL fl_drain_hold: got %b%b/%h want 11/300", stall_req, ram_req, ram_addr);
    end
    @(negedge clk);
    ram_ack = 1'b1; ram_rdata = 32'h11111111;
    #1;
    checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL fl_drain_valid: got %b want 0", load_valid); end
    @(negedge clk);
    ram_ack = 1'b0; ram_rdata = 32'h0;
    #1;
    checks++; if ({stall_req, ram_req, load_valid} !== 3'b100) begin
      errors++; $display("FAIL fl_idle_after: got %b want 100", {stall_req, ram_req, load_valid});
    end
    @(negedge clk);
    #1;
    checks++; if ({ram_req, ram_addr} !== {1'b1, 32'h400}) begin
      errors++; $display("FAIL fl_next_req: got %b/%h want 1/400", ram_req, ram_addr);
    end
    ram_ack = 1'b1; ram_rdata = 32'h12345678;
    @(negedge clk);
    ram_ack = 1'b0;
    #1;
    checks++; if ({load_valid, load_data} !== {1'b1, 32'h12345678}) begin
      errors++; $display("FAIL fl_next_load: got %b/%h want 1/12345678", load_valid, load_data);
    end
    rd_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    rd_in = 1'b1; size_in = MemSizeW; addr_in = 32'h500;
    @(negedge clk);
    #1;
    checks++; if (ram_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b want 1", ram_req); end
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (ram_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b want 0", ram_req); end
    rd_in = 1'b0; rst = 1'b1;
    @(negedge clk);
    ram_ack = 1'b1;
    #1;
    checks++; if ({stall_req, ram_req} !== 2'b00) begin
      errors++; $display("FAIL rst_idle: got %b want 00", {stall_req, ram_req});
    end
    @(negedge clk);
    ram_ack = 1'b0;
    #1;
    checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL rst_no_valid: got %b want 0", load_valid); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_extend();
    test_store();
    test_misaligned();
    test_timeout();
    test_flush_drain();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
